pipe_reg_skid: RTL
==================

PIPE_REG_SKID -- requirements
Module: pipe_reg_skid

Interface
REQ-001 Parameter DATA_W, default 64: payload width in bits (PC concatenated with instruction).
REQ-002 Parameter FLUSH_VAL, default 0: value loaded into both data registers on reset and flush (DATA_W bits).
REQ-003 Port clk, input, 1: single clock; all state updates on rising edge.
REQ-004 Port rst, input, 1: reset, asynchronous assert and active-low (0 = reset).
REQ-005 Port freeze, input, 1: stall; holds all state and blocks both handshakes.
REQ-006 Port flush, input, 1: synchronous discard of all held entries.
REQ-007 Port in_valid, input, 1: upstream has a payload.
REQ-008 Port in_ready, output, 1: block accepts a payload this cycle.
REQ-009 Port in_data, input, DATA_W: upstream payload.
REQ-010 Port out_valid, output, 1: out_data is valid.
REQ-011 Port out_ready, input, 1: downstream accepts a payload.
REQ-012 Port out_data, output, DATA_W: head payload, driven directly from the main register.
REQ-013 Port occ, output, 2: entries held (0, 1 or 2).

Function
REQ-014 in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
REQ-015 State machine: EMPTY (occ=0), ONE (main valid), FULL (main and skid valid).
REQ-016 in_ready = ~freeze & (state != FULL), derived only from registered state and freeze, with no combinational path from out_ready.
REQ-017 out_valid = ~freeze & (state != EMPTY).
REQ-018 EMPTY: on in_fire, main <= in_data and go to ONE; otherwise stay.
REQ-019 ONE: in_fire & out_fire means main <= in_data and stay; in_fire only means skid <= in_data and go to FULL; out_fire only means go to EMPTY.
REQ-020 FULL: on out_fire, main <= skid and go to ONE; otherwise stay.
REQ-021 Latency in_fire to out_valid is exactly 1 cycle when EMPTY; order is strictly FIFO; no payload is lost or duplicated.
REQ-022 Sustained throughput is 1 payload/cycle while out_ready=1.
REQ-023 freeze=1: no state or data register changes; in_ready=0 and out_valid=0 during that cycle.
REQ-024 flush=1: next state EMPTY and main/skid <= FLUSH_VAL, regardless of freeze, in_valid or out_ready; a payload offered in the flush cycle is dropped.
REQ-025 Priority: rst > flush > freeze > handshake.
REQ-026 occ reflects the registered state: EMPTY=0, ONE=1, FULL=2; value 3 never appears.

Reset
REQ-027 While rst=0: state EMPTY, main=skid=FLUSH_VAL, in_ready=0, out_valid=0, occ=0, immediately and independent of clk.
REQ-028 Reset mid-transfer discards all held entries; after rst rises, the first clk edge behaves as from EMPTY.
REQ-029 With freeze=0 after reset, in_ready=1 in the first cycle after rst deasserts.

Configuration
REQ-030 Macro PIPE_REG_SKID_STALL_CNT_EN defined: the block adds output stall_cnt (16 bits), which increments on each cycle with out_valid & ~out_ready, saturates at 16'hFFFF, clears on reset and flush, and holds during freeze.
REQ-031 Macro PIPE_REG_SKID_STALL_CNT_EN undefined: port stall_cnt and its logic are absent; all other behaviour is identical.

Verification
REQ-032 Stream: rst pulse, then in_data=1..8 on consecutive cycles with out_ready=1 -> out_data=1..8 one cycle later, back-to-back, occ=1 throughout.
REQ-033 Backpressure: out_ready=0 while offering A=0xAA then B=0xBB -> occ=2 and in_ready=0. Then out_ready=1 -> A, then B, in order; C=0xCC is not accepted until in_ready=1.
REQ-034 Freeze: in FULL with A, B held, freeze=1 for 3 cycles -> in_ready=0, out_valid=0, occ=2 unchanged. Release -> A presented.
REQ-035 Flush: in FULL with flush=1 and freeze=1 together -> next cycle occ=0, out_valid=0, out_data=FLUSH_VAL; the in_valid payload offered that cycle never appears.
REQ-036 Async reset: assert rst=0 between clock edges while occ=2 -> occ=0 and out_valid=0 before the next edge.
REQ-037 Stall counter (macro on): out_valid=1, out_ready=0 for 5 cycles -> stall_cnt=5. Flush -> 0. Force 70000 stall cycles -> stall_cnt=16'hFFFF.

Source files
------------

// File: rtl/pipe_reg_skid.sv
// rtl/pipe_reg_skid.sv - two-entry skid pipeline register with fully registered in_ready
//
// Purpose: pipeline stage that breaks the combinational ready path. A main
// register drives out_data directly. A skid register catches the one payload
// that can arrive while the downstream stalls.
//
// Optional feature: define PIPE_REG_SKID_STALL_CNT_EN to add the stall_cnt output.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   freeze     stall; holds all state and blocks both handshakes
//   flush      synchronous discard of all held entries
//   in_valid   upstream payload present
//   in_ready   block accepts a payload this cycle
//   in_data    upstream payload, DATA_W bits
//   out_valid  out_data is valid
//   out_ready  downstream accepts a payload
//   out_data   head payload, driven from the main register
//   occ        entries held (0..2)
//   stall_cnt  saturating count of out_valid & ~out_ready cycles (optional)
module pipe_reg_skid #(
  parameter int                 DATA_W    = 64,
  parameter logic [DATA_W-1:0]  FLUSH_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              freeze,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
`ifdef PIPE_REG_SKID_STALL_CNT_EN
  output logic [1:0]        occ,
  output logic [15:0]       stall_cnt
`else
  output logic [1:0]        occ
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] main_q;
  logic [DATA_W-1:0] skid_q;
  logic              in_fire;
  logic              out_fire;

  // Ready depends only on registered state, freeze and reset; out_ready never
  // reaches in_ready, which is the point of the skid entry. Reset gating keeps
  // both handshakes closed while rst is low.
  assign in_ready  = rst & ~freeze & (state != FULL);
  assign out_valid = rst & ~freeze & (state != EMPTY);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;
  assign out_data  = main_q;

  always_comb begin
    occ = 2'd0;
    case (state)
      EMPTY:   occ = 2'd0;
      ONE:     occ = 2'd1;
      FULL:    occ = 2'd2;
      default: occ = 2'd0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= EMPTY;
      main_q <= FLUSH_VAL;
      skid_q <= FLUSH_VAL;
    end else if (flush) begin
      state  <= EMPTY;
      main_q <= FLUSH_VAL;
      skid_q <= FLUSH_VAL;
    end else if (!freeze) begin
      // freeze already forces both fire terms low; this branch just makes the
      // hold explicit.
      case (state)
        EMPTY: begin
          if (in_fire) begin
            main_q <= in_data;
            state  <= ONE;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_q <= in_data;
          end else if (in_fire) begin
            skid_q <= in_data;
            state  <= FULL;
          end else if (out_fire) begin
            state  <= EMPTY;
          end
        end
        FULL: begin
          if (out_fire) begin
            main_q <= skid_q;
            state  <= ONE;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

`ifdef PIPE_REG_SKID_STALL_CNT_EN
  // out_valid is already low under freeze, so the counter holds without an
  // explicit freeze term.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= 16'd0;
    end else if (flush) begin
      stall_cnt <= 16'd0;
    end else if (out_valid && !out_ready && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule
